// File: rtl/mp_add_stream.sv
// mp_add_stream
//   Multi-precision streaming adder/subtractor. Long operands arrive as W-bit
//   beats, least-significant beat first. Each beat goes through a ripple of
//   16-bit carry-lookahead slices. The carry between beats is kept in a
//   register, and results leave through a 2-entry valid/ready buffer.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   operand beat present
//   in_ready   out  block can accept a beat (count < 2, forced low in reset)
//   in_a/in_b  in   W-bit operand beats
//   in_last    in   beat is the most-significant beat of the operation
//   in_op      in   0 = A+B, 1 = A-B; only sampled on the first beat
//   out_valid  out  result beat present
//   out_ready  in   consumer accepts result beat
//   out_sum    out  W-bit result beat (0 when buffer empty)
//   out_last   out  final beat of the operation
//   out_cout   out  carry out of final beat (1 = no borrow on subtract)
//   out_zero   out  whole result was zero (final beat only)

module mp_add_stream #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_last,
  input  logic         in_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_last,
  output logic         out_cout,
  output logic         out_zero
);

  localparam int NS = W / 16;
  localparam int EW = W + 3;

  localparam logic ST_FIRST = 1'b0;
  localparam logic ST_MID   = 1'b1;

  logic          state_q, state_d;
  logic          carry_q, carry_d;
  logic          op_q, op_d;
  logic          zacc_q, zacc_d;
  logic [EW-1:0] mem_q [2];
  logic          rdPtr_q;
  logic          wrPtr_q;
  logic [1:0]    count_q;

  logic          isFirst;
  logic          opEff;
  logic [W-1:0]  bEff;
  logic [NS:0]   chain;
  logic [W-1:0]  sumBeat;
  logic          beatCout;
  logic          sumZero;
  logic          zeroFinal;
  logic          push;
  logic          pop;
  logic [EW-1:0] headEntry;

  // 16-bit two-level carry-lookahead slice: four 4-bit groups, each with its
  // own generate/propagate, joined by a second lookahead level.
  function automatic logic [16:0] cla16(input logic [15:0] a,
                                        input logic [15:0] b,
                                        input logic        cin);
    logic [15:0] g, p, c;
    logic [3:0]  gg, pg;
    logic [4:0]  cg;
    g = a & b;
    p = a ^ b;
    for (int j = 0; j < 4; j++) begin
      gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      pg[j] = &p[4*j +: 4];
    end
    cg[0] = cin;
    cg[1] = gg[0] | (pg[0] & cin);
    cg[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & cin);
    cg[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0]) | (pg[2] & pg[1] & pg[0] & cin);
    cg[4] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
          | (pg[3] & pg[2] & pg[1] & gg[0]) | ((&pg) & cin);
    for (int j = 0; j < 4; j++) begin
      c[4*j]   = cg[j];
      c[4*j+1] = g[4*j] | (p[4*j] & cg[j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & cg[j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & cg[j]);
    end
    return {cg[4], p ^ c};
  endfunction

  // Handshakes. in_ready deliberately ignores out_ready so a full buffer
  // only frees a slot on the edge after the pop.
  assign in_ready  = !rst && (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Beat datapath. On a first beat the op bit doubles as carry-in, which
  // turns ~B + 1 into a two's-complement subtract.
  always_comb begin
    isFirst = (state_q == ST_FIRST);
    opEff   = isFirst ? in_op : op_q;
    bEff    = opEff ? ~in_b : in_b;
    chain   = '0;
    sumBeat = '0;
    chain[0] = isFirst ? in_op : carry_q;
    for (int s = 0; s < NS; s++) begin
      {chain[s+1], sumBeat[16*s +: 16]} = cla16(in_a[16*s +: 16], bEff[16*s +: 16], chain[s]);
    end
    beatCout  = chain[NS];
    sumZero   = (sumBeat == '0);
    zeroFinal = sumZero && (isFirst || zacc_q);
  end

  // Operation state advances only on accepted beats, so input gaps hold
  // carry, zero accumulator and op indefinitely.
  always_comb begin
    state_d = state_q;
    carry_d = carry_q;
    op_d    = op_q;
    zacc_d  = zacc_q;
    if (push) begin
      carry_d = beatCout;
      op_d    = opEff;
      zacc_d  = isFirst ? sumZero : (zacc_q && sumZero);
      state_d = in_last ? ST_FIRST : ST_MID;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FIRST;
      carry_q <= 1'b0;
      op_q    <= 1'b0;
      zacc_q  <= 1'b0;
      rdPtr_q <= 1'b0;
      wrPtr_q <= 1'b0;
      count_q <= 2'd0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
      op_q    <= op_d;
      zacc_q  <= zacc_d;
      if (push) begin
        wrPtr_q <= ~wrPtr_q;
      end
      if (pop) begin
        rdPtr_q <= ~rdPtr_q;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Buffer storage needs no reset: the count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= {sumBeat, in_last, in_last & beatCout, in_last & zeroFinal};
    end
  end

  assign headEntry = mem_q[rdPtr_q];
  assign out_sum   = out_valid ? headEntry[EW-1:3] : '0;
  assign out_last  = out_valid & headEntry[2];
  assign out_cout  = out_valid & headEntry[1];
  assign out_zero  = out_valid & headEntry[0];

endmodule
